vector_proc_seq: RTL and testbench

Parametrised, multi-cycle successor to the team's 512-bit vector processor. It holds NREG vector registers of LANES x EW-bit signed lanes and a DEPTH-word data memory. It executes one command per start pulse: LOAD, STORE, ADD, SUB, MUL or MULH. Memory transfers take one lane per cycle, and completion is signalled by a busy/done handshake. It is the compute core in DSD lab designs; a bench or controller drives commands and preloads memory through a side port.

---
 rtl/vproc_pkg.sv | 41 ++++
 rtl/vector_proc_seq_if.sv | 32 +++
 rtl/vec_lane_alu.sv | 44 ++++
 rtl/vector_proc_seq.sv | 150 +++++++++++++++
 tb/tb_vector_proc_seq.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vproc_pkg.sv
// Shared definitions for the sequential vector processor.
//   opcode_e : 3-bit command opcode (6 and 7 are illegal)
//   state_e  : control FSM states
//   *_DEF    : default geometry (lanes, lane width, memory depth, register count)
//   lane_lsb : bit offset of a lane inside a packed vector register
//   is_alu   : true for the register-to-register opcodes
package vproc_pkg;

    localparam int LANES_DEF = 16;
    localparam int EW_DEF    = 32;
    localparam int DEPTH_DEF = 512;
    localparam int NREG_DEF  = 4;

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_MUL   = 3'd4,
        OP_MULH  = 3'd5,
        OP_ILL6  = 3'd6,
        OP_ILL7  = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_XFER,
        S_EXEC,
        S_FIN
    } state_e;

    // Lane 0 sits in the least significant EW bits of a register.
    function automatic int lane_lsb(input int lane, input int ew);
        return lane * ew;
    endfunction

    function automatic logic is_alu(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_MUL, OP_MULH};
    endfunction

endpackage

// File: rtl/vector_proc_seq_if.sv
// Command handshake between a controller and the vector processor.
//   start, opcode, addr, rd, rs1, rs2 : command from the controller
//   busy, done, err                   : status back from the processor
// master = controller side, slave = processor side.
interface vector_proc_seq_if
    import vproc_pkg::*;
#(
    parameter int AW = $clog2(DEPTH_DEF) + 1,
    parameter int RW = $clog2(NREG_DEF)
) ();

    logic          start;
    logic [2:0]    opcode;
    logic [AW-1:0] addr;
    logic [RW-1:0] rd;
    logic [RW-1:0] rs1;
    logic [RW-1:0] rs2;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        output start, opcode, addr, rd, rs1, rs2,
        input  busy, done, err
    );

    modport slave (
        input  start, opcode, addr, rd, rs1, rs2,
        output busy, done, err
    );

endinterface

// File: rtl/vec_lane_alu.sv
// Combinational lane-wise ALU for the vector processor.
//   a, b   : packed vector operands, LANES lanes of EW-bit signed values
//   op     : ADD/SUB wrap, MUL keeps the low half of the signed product,
//            MULH keeps the high half; any other opcode yields zero
//   result : packed lane-wise result
module vec_lane_alu
    import vproc_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int EW    = EW_DEF
) (
    input  logic [LANES*EW-1:0] a,
    input  logic [LANES*EW-1:0] b,
    input  opcode_e             op,
    output logic [LANES*EW-1:0] result
);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [EW-1:0]   la;
        logic signed [EW-1:0]   lb;
        logic signed [2*EW-1:0] prod;
        logic        [EW-1:0]   res;

        assign la = a[lane_lsb(g, EW) +: EW];
        assign lb = b[lane_lsb(g, EW) +: EW];

        // Sign-extend explicitly so the 2*EW-bit product is the full signed product.
        assign prod = {{EW{la[EW-1]}}, la} * {{EW{lb[EW-1]}}, lb};

        always_comb begin
            // NOTE: res gets a value on every path (default arm) so no latch is inferred.
            case (op)
                OP_ADD:  res = la + lb;
                OP_SUB:  res = la - lb;
                OP_MUL:  res = prod[EW-1:0];
                OP_MULH: res = prod[2*EW-1:EW];
                default: res = '0;
            endcase
        end

        assign result[lane_lsb(g, EW) +: EW] = res;
    end

endmodule

// File: rtl/vector_proc_seq.sv
// Multi-cycle vector processor: NREG registers of LANES x EW-bit signed lanes
// and a DEPTH-word data memory. One command per start pulse in IDLE.
//   clk, rst             : clock, synchronous active-high reset
//   cmd (slave)          : start/opcode/addr/rd/rs1/rs2 in, busy/done/err out
//   mem_we/waddr/wdata   : memory preload, honoured only while not busy
//   dbg_reg/lane -> data : combinational register lane read
//   dbg_maddr -> mdata   : combinational memory read
// LOAD/STORE move one lane per cycle and clip (never wrap) at the end of memory.
module vector_proc_seq
    import vproc_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int EW    = EW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int AW    = $clog2(DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    vector_proc_seq_if.slave         cmd,
    input  logic                     mem_we,
    input  logic [$clog2(DEPTH)-1:0] mem_waddr,
    input  logic [EW-1:0]            mem_wdata,
    input  logic [$clog2(NREG)-1:0]  dbg_reg,
    input  logic [$clog2(LANES)-1:0] dbg_lane,
    output logic [EW-1:0]            dbg_data,
    input  logic [$clog2(DEPTH)-1:0] dbg_maddr,
    output logic [EW-1:0]            dbg_mdata
);

    localparam int RW = $clog2(NREG);
    localparam int LW = $clog2(LANES);
    localparam int MW = $clog2(DEPTH);
    localparam int VW = LANES * EW;
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [AW:0]   DEPTH_X = (AW+1)'(DEPTH);

    state_e        state_q, state_d;
    opcode_e       op_q;
    logic [AW-1:0] addr_q;
    logic [RW-1:0] rd_q, rs1_q, rs2_q;
    logic [LW-1:0] lane_q;
    logic          err_q;

    logic [VW-1:0] vreg [NREG];
    logic [EW-1:0] mem  [DEPTH];

    // Command decode in IDLE. ALU ops ignore addr entirely.
    opcode_e op_in;
    logic    is_xfer_in;
    logic    accept;

    assign op_in      = opcode_e'(cmd.opcode);
    assign is_xfer_in = (op_in == OP_LOAD) || (op_in == OP_STORE);
    assign accept     = is_alu(op_in) || (is_xfer_in && (cmd.addr < DEPTH_A));

    // Current transfer address; one extra bit so addr+lane never wraps.
    logic [AW:0]   xaddr;
    logic          in_range;
    logic          last_lane;
    logic [EW-1:0] load_word;
    logic [EW-1:0] store_word;
    logic [VW-1:0] alu_result;

    assign xaddr      = {1'b0, addr_q} + (AW+1)'(lane_q);
    assign in_range   = xaddr < DEPTH_X;
    assign last_lane  = lane_q == LW'(LANES - 1);
    assign load_word  = in_range ? mem[xaddr[MW-1:0]] : '0;
    assign store_word = vreg[rd_q][lane_lsb(int'(lane_q), EW) +: EW];

    // Operands come from the register file before the EXEC write, so rd may alias rs1/rs2.
    vec_lane_alu #(.LANES(LANES), .EW(EW)) u_alu (
        .a      (vreg[rs1_q]),
        .b      (vreg[rs2_q]),
        .op     (op_q),
        .result (alu_result)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd.start) begin
                    if (!accept)         state_d = S_FIN;
                    else if (is_xfer_in) state_d = S_XFER;
                    else                 state_d = S_EXEC;
                end
            end
            S_XFER:  if (last_lane) state_d = S_FIN;
            S_EXEC:  state_d = S_FIN;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            op_q    <= OP_LOAD;
            addr_q  <= '0;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) vreg[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (cmd.start) begin
                        err_q <= !accept;
                        if (accept) begin
                            op_q   <= op_in;
                            addr_q <= cmd.addr;
                            rd_q   <= cmd.rd;
                            rs1_q  <= cmd.rs1;
                            rs2_q  <= cmd.rs2;
                            lane_q <= '0;
                        end
                    end
                end
                S_XFER: begin
                    lane_q <= lane_q + LW'(1);
                    if (op_q == OP_LOAD)
                        vreg[rd_q][lane_lsb(int'(lane_q), EW) +: EW] <= load_word;
                end
                S_EXEC:  vreg[rd_q] <= alu_result;
                default: ;
            endcase
        end
    end

    // NOTE: the data memory is deliberately not reset; it keeps its contents across rst.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_XFER && op_q == OP_STORE) begin
            if (in_range) mem[xaddr[MW-1:0]] <= store_word;
        end else if (mem_we && !cmd.busy) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign cmd.busy  = (state_q == S_XFER) || (state_q == S_EXEC);
    assign cmd.done  = (state_q == S_FIN);
    assign cmd.err   = (state_q == S_FIN) && err_q;

    assign dbg_data  = vreg[dbg_reg][lane_lsb(int'(dbg_lane), EW) +: EW];
    assign dbg_mdata = mem[dbg_maddr];

endmodule

// File: tb/tb_vector_proc_seq.sv
// Directed bench for vector_proc_seq with a scoreboard: command status
// (latency, busy cycles, err) and result data are queued when a command is
// issued and compared when the processor signals done.
`timescale 1ns/1ps
module tb_vector_proc_seq;
    import vproc_pkg::*;

    localparam int LANES = 16;
    localparam int EW    = 32;
    localparam int DEPTH = 512;
    localparam int NREG  = 4;
    localparam int AW    = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [8:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [1:0]  dbg_reg;
    logic [3:0]  dbg_lane;
    logic [31:0] dbg_data;
    logic [8:0]  dbg_maddr;
    logic [31:0] dbg_mdata;

    always #5 clk = ~clk;

    vector_proc_seq_if #(.AW(AW), .RW(2)) cmd ();

    vector_proc_seq #(
        .LANES(LANES), .EW(EW), .DEPTH(DEPTH), .NREG(NREG), .AW(AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .dbg_reg   (dbg_reg),
        .dbg_lane  (dbg_lane),
        .dbg_data  (dbg_data),
        .dbg_maddr (dbg_maddr),
        .dbg_mdata (dbg_mdata)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] sb_meta [$];
    logic [31:0] sb_data [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_meta(input string tag, input logic [31:0] obs);
        if (sb_meta.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
        end else begin
            check(tag, obs, sb_meta.pop_front());
        end
    endtask

    task automatic pop_data(input string tag, input logic [31:0] obs);
        if (sb_data.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h expected <empty scoreboard>", tag, obs);
        end else begin
            check(tag, obs, sb_data.pop_front());
        end
    endtask

    function automatic logic [31:0] mulh_model(input int a, input int b);
        longint p;
        p = longint'(a) * longint'(b);
        return p[63:32];
    endfunction

    task automatic preload(input int a, input logic [31:0] v);
        @(negedge clk);
        mem_we    = 1'b1;
        mem_waddr = 9'(a);
        mem_wdata = v;
        @(negedge clk);
        mem_we    = 1'b0;
    endtask

    task automatic drain_lane(input string tag, input int r, input int l);
        dbg_reg  = 2'(r);
        dbg_lane = 4'(l);
        #1;
        pop_data($sformatf("%s_r%0d_l%0d", tag, r, l), dbg_data);
    endtask

    task automatic drain_reg(input string tag, input int r);
        for (int l = 0; l < LANES; l++) drain_lane(tag, r, l);
    endtask

    task automatic drain_mem(input string tag, input int a);
        dbg_maddr = 9'(a);
        #1;
        pop_data($sformatf("%s_m%0d", tag, a), dbg_mdata);
    endtask

    // Drive start for one edge; returns #1 after that edge (cycle 1 of the command).
    task automatic issue(input logic [2:0] op, input int a, input int d, input int s1, input int s2);
        @(negedge clk);
        cmd.start  = 1'b1;
        cmd.opcode = op;
        cmd.addr   = AW'(a);
        cmd.rd     = 2'(d);
        cmd.rs1    = 2'(s1);
        cmd.rs2    = 2'(s2);
        @(posedge clk);
        #1;
        cmd.start  = 1'b0;
    endtask

    // Issue a command and check latency, busy cycle count and err at done.
    // With poke set, a start and a preload write are attempted while busy,
    // and another start is held during the done cycle.
    task automatic run(input string tag, input logic [2:0] op, input int a, input int d,
                       input int s1, input int s2, input int lat, input int nbusy,
                       input logic e, input bit poke);
        int c;
        int busy_n;
        sb_meta.push_back(32'(lat));
        sb_meta.push_back(32'(nbusy));
        sb_meta.push_back({31'd0, e});
        issue(op, a, d, s1, s2);
        c      = 1;
        busy_n = 0;
        while (cmd.done !== 1'b1 && c < 64) begin
            if (cmd.busy === 1'b1) busy_n++;
            if (poke && c == 3) begin
                cmd.start  = 1'b1;
                cmd.opcode = 3'(OP_ADD);
                cmd.rd     = 2'd3;
                cmd.rs1    = 2'd2;
                cmd.rs2    = 2'd2;
                mem_we     = 1'b1;
                mem_waddr  = 9'd100;
                mem_wdata  = 32'h0000_DEAD;
            end
            if (poke && c == 4) begin
                cmd.start = 1'b0;
                mem_we    = 1'b0;
            end
            @(posedge clk);
            #1;
            c++;
        end
        pop_meta({tag, "_lat"}, 32'(c));
        pop_meta({tag, "_busy_cycles"}, 32'(busy_n));
        pop_meta({tag, "_err"}, {31'd0, cmd.err});
        if (poke) begin
            cmd.start  = 1'b1;
            cmd.opcode = 3'(OP_ADD);
        end
        @(posedge clk);
        #1;
        cmd.start = 1'b0;
        check({tag, "_done_pulse"}, {31'd0, cmd.done}, 32'd0);
        check({tag, "_idle"}, {31'd0, cmd.busy}, 32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: observed timeout expected summary before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        cmd.start  = 1'b0;
        cmd.opcode = '0;
        cmd.addr   = '0;
        cmd.rd     = '0;
        cmd.rs1    = '0;
        cmd.rs2    = '0;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_wdata  = '0;
        dbg_reg    = '0;
        dbg_lane   = '0;
        dbg_maddr  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, cmd.busy}, 32'd0);
        check("rst_done", {31'd0, cmd.done}, 32'd0);
        check("rst_err",  {31'd0, cmd.err},  32'd0);
        dbg_reg  = 2'd1;
        dbg_lane = 4'd5;
        #1;
        check("rst_reg", dbg_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // LOAD with in-range addresses; start and preload while busy are dropped
        for (int k = 0; k < LANES; k++) preload(5 + k, 32'(k + 1));
        preload(100, 32'h0000_1234);
        for (int k = 0; k < LANES; k++) sb_data.push_back(32'(k + 1));
        run("load5", 3'(OP_LOAD), 5, 2, 0, 0, 17, 16, 1'b0, 1'b1);
        drain_reg("load5", 2);
        sb_data.push_back(32'd0);
        drain_lane("busy_start_ignored", 3, 0);
        sb_data.push_back(32'h0000_1234);
        drain_mem("busy_we_dropped", 100);

        // LOAD clipping at the top of memory
        for (int k = 0; k < 12; k++) preload(500 + k, 32'hA0 + 32'(k));
        for (int k = 0; k < LANES; k++) sb_data.push_back(k < 12 ? 32'hA0 + 32'(k) : 32'd0);
        run("load500", 3'(OP_LOAD), 500, 0, 0, 0, 17, 16, 1'b0, 1'b0);
        drain_reg("load500", 0);

        // STORE clipping: only 508..511 written, 507 untouched
        for (int k = 0; k < LANES; k++) preload(30 + k, 32'hFFFF_FFFF);
        run("load_m1", 3'(OP_LOAD), 30, 1, 0, 0, 17, 16, 1'b0, 1'b0);
        sb_data.push_back(32'hA7);
        for (int k = 0; k < 4; k++) sb_data.push_back(32'hFFFF_FFFF);
        run("store508", 3'(OP_STORE), 508, 1, 0, 0, 17, 16, 1'b0, 1'b0);
        for (int a = 507; a < 512; a++) drain_mem("store508", a);

        // ALU ops: reg0 = -10, reg1 = 2345
        for (int k = 0; k < LANES; k++) preload(60 + k, 32'(-10));
        for (int k = 0; k < LANES; k++) preload(80 + k, 32'(2345));
        run("load_a", 3'(OP_LOAD), 60, 0, 0, 0, 17, 16, 1'b0, 1'b0);
        run("load_b", 3'(OP_LOAD), 80, 1, 0, 0, 17, 16, 1'b0, 1'b0);

        for (int k = 0; k < LANES; k++) sb_data.push_back(32'(-10 * 2345));
        run("mul", 3'(OP_MUL), 0, 2, 0, 1, 2, 1, 1'b0, 1'b0);
        drain_reg("mul", 2);

        for (int k = 0; k < LANES; k++) sb_data.push_back(mulh_model(-10, 2345));
        run("mulh", 3'(OP_MULH), 0, 3, 0, 1, 2, 1, 1'b0, 1'b0);
        drain_reg("mulh", 3);

        for (int k = 0; k < LANES; k++) sb_data.push_back(32'(-10 - 2345));
        run("sub", 3'(OP_SUB), 0, 3, 0, 1, 2, 1, 1'b0, 1'b0);
        drain_reg("sub", 3);

        for (int k = 0; k < LANES; k++) sb_data.push_back(32'(-10 + 2345));
        run("add_alias", 3'(OP_ADD), 0, 0, 0, 1, 2, 1, 1'b0, 1'b0);
        drain_reg("add_alias", 0);

        // Distinct lane values through the multiplier
        run("reload5", 3'(OP_LOAD), 5, 2, 0, 0, 17, 16, 1'b0, 1'b0);
        for (int k = 0; k < LANES; k++) sb_data.push_back(32'((k + 1) * (k + 1)));
        run("mul_sq", 3'(OP_MUL), 0, 3, 2, 2, 2, 1, 1'b0, 1'b0);
        drain_reg("mul_sq", 3);

        // Signed wrap on ADD
        for (int k = 0; k < LANES; k++) preload(120 + k, 32'h7FFF_FFFF);
        for (int k = 0; k < LANES; k++) preload(140 + k, 32'd1);
        run("load_max", 3'(OP_LOAD), 120, 0, 0, 0, 17, 16, 1'b0, 1'b0);
        run("load_one", 3'(OP_LOAD), 140, 1, 0, 0, 17, 16, 1'b0, 1'b0);
        for (int k = 0; k < LANES; k++) sb_data.push_back(32'h8000_0000);
        run("add_wrap", 3'(OP_ADD), 0, 2, 0, 1, 2, 1, 1'b0, 1'b0);
        drain_reg("add_wrap", 2);

        // Rejected commands: one-cycle done with err, nothing changes
        run("ill6", 3'd6, 0, 2, 0, 1, 1, 0, 1'b1, 1'b0);
        run("ill7", 3'd7, 0, 2, 0, 1, 1, 0, 1'b1, 1'b0);
        run("load512", 3'(OP_LOAD), 512, 2, 0, 0, 1, 0, 1'b1, 1'b0);
        run("store1023", 3'(OP_STORE), 1023, 1, 0, 0, 1, 0, 1'b1, 1'b0);
        for (int k = 0; k < LANES; k++) sb_data.push_back(32'h8000_0000);
        drain_reg("after_reject", 2);
        sb_data.push_back(32'hFFFF_FFFF);
        drain_mem("after_reject", 511);

        // ALU ops ignore addr, even when out of range
        sb_data.push_back(32'd0);
        run("add_hiaddr", 3'(OP_ADD), 600, 3, 2, 2, 2, 1, 1'b0, 1'b0);
        drain_lane("add_hiaddr", 3, 0);

        // Reset in the middle of a LOAD, during the lane-7 cycle
        issue(3'(OP_LOAD), 5, 2, 0, 0);
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        check("mid_busy", {31'd0, cmd.busy}, 32'd1);
        sb_data.push_back(32'd7);
        drain_lane("partial", 2, 6);
        sb_data.push_back(32'h8000_0000);
        drain_lane("partial", 2, 7);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, cmd.busy}, 32'd0);
        check("abort_done", {31'd0, cmd.done}, 32'd0);
        for (int r = 0; r < NREG; r++) begin
            for (int k = 0; k < LANES; k++) sb_data.push_back(32'd0);
            drain_reg("abort", r);
        end
        sb_data.push_back(32'd1);
        drain_mem("abort_mem_kept", 5);
        @(negedge clk);
        rst = 1'b0;

        // Normal operation after the abort
        for (int k = 0; k < LANES; k++) sb_data.push_back(32'(k + 1));
        run("post_rst_load", 3'(OP_LOAD), 5, 1, 0, 0, 17, 16, 1'b0, 1'b0);
        drain_reg("post_rst_load", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
